// File: rtl/mmu_bounds_guard_pkg.sv
// Shared definitions for the MMU bounds guard.
// Holds the default widths and table size, the guard FSM state type and the
// inclusive unsigned range test used against the segment limits.
package mmu_bounds_guard_pkg;

  localparam int ADDR_W_DEF = 26;
  localparam int SEL_W_DEF  = 4;
  localparam int NSEG_DEF   = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FWD   = 2'd2,
    FAULT = 2'd3
  } state_e;

  // Inclusive unsigned window test; an inverted window (lo > hi) never matches.
  function automatic logic in_range(input logic [31:0] a,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/mmu_bounds_table.sv
// Per-selector segment limit table plus the active selector.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   we, sel            write strobe and selector (selector also becomes active)
//   lower, upper       inclusive limits written into entry sel
//   rd_sel             selector to read (the selector latched with a request)
//   active_sel         selector of the most recent write
//   rd_valid           rd_sel names a real entry
//   rd_lower, rd_upper limits of entry rd_sel (zero when rd_sel is invalid)
module mmu_bounds_table
  import mmu_bounds_guard_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int NSEG  = NSEG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [SEL_W-1:0] sel,
  input  logic [31:0]      lower,
  input  logic [31:0]      upper,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [SEL_W-1:0] active_sel,
  output logic             rd_valid,
  output logic [31:0]      rd_lower,
  output logic [31:0]      rd_upper
);

  logic [31:0]      lower_q [NSEG];
  logic [31:0]      upper_q [NSEG];
  logic [SEL_W-1:0] active_sel_q;
  logic             wr_ok;

  assign wr_ok = 32'(sel) < NSEG;

  // An out-of-range selector still becomes active so later requests fault,
  // but it must never touch the stored limits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        lower_q[i] <= '0;
        upper_q[i] <= '0;
      end
      active_sel_q <= '0;
    end else if (we) begin
      active_sel_q <= sel;
      if (wr_ok) begin
        lower_q[sel] <= lower;
        upper_q[sel] <= upper;
      end
    end
  end

  assign active_sel = active_sel_q;
  assign rd_valid   = 32'(rd_sel) < NSEG;
  assign rd_lower   = rd_valid ? lower_q[rd_sel] : '0;
  assign rd_upper   = rd_valid ? upper_q[rd_sel] : '0;

endmodule

// File: rtl/mmu_bounds_guard.sv
// Protection stage behind the MMU: checks each translated physical address
// against the limits of the selector active when the request was accepted,
// then either forwards it to data memory or raises a held protection fault.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   we, sel, lower, upper          limit-table write port (shared with MMU)
//   req_valid/req_ready            request handshake from the MMU stage
//   req_addr, req_wr               physical address and direction (1 = store)
//   mem_valid/mem_ready            forwarded access handshake to data memory
//   mem_addr, mem_wr               forwarded address and direction
//   exc, exc_ack                   pending fault and its acknowledge
//   exc_addr, exc_sel              address and selector of the last fault
module mmu_bounds_guard
  import mmu_bounds_guard_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int NSEG   = NSEG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [SEL_W-1:0]  sel,
  input  logic [31:0]       lower,
  input  logic [31:0]       upper,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wr,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              exc,
  output logic [ADDR_W-1:0] exc_addr,
  output logic [SEL_W-1:0]  exc_sel,
  input  logic              exc_ack
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [SEL_W-1:0]  sel_q;
  logic              req_ready_q;
  logic              mem_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wr_q;
  logic              exc_q;
  logic [ADDR_W-1:0] exc_addr_q;
  logic [SEL_W-1:0]  exc_sel_q;

  logic [SEL_W-1:0]  active_sel;
  logic              rd_valid;
  logic [31:0]       rd_lower;
  logic [31:0]       rd_upper;
  logic              pass_d;

  // The read port follows the latched selector, so writes after acceptance
  // can change limits but never which entry an in-flight request uses.
  mmu_bounds_table #(
    .SEL_W (SEL_W),
    .NSEG  (NSEG)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .sel        (sel),
    .lower      (lower),
    .upper      (upper),
    .rd_sel     (sel_q),
    .active_sel (active_sel),
    .rd_valid   (rd_valid),
    .rd_lower   (rd_lower),
    .rd_upper   (rd_upper)
  );

  assign pass_d = rd_valid && in_range(32'(addr_q), rd_lower, rd_upper);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      sel_q       <= '0;
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      exc_q       <= 1'b0;
      exc_addr_q  <= '0;
      exc_sel_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // active_sel is the registered value, so a same-cycle table
          // write does not retarget this request.
          if (req_valid) begin
            addr_q      <= req_addr;
            wr_q        <= req_wr;
            sel_q       <= active_sel;
            req_ready_q <= 1'b0;
            state_q     <= CHECK;
          end
        end
        CHECK: begin
          if (pass_d) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wr_q    <= wr_q;
            state_q     <= FWD;
          end else begin
            exc_q      <= 1'b1;
            exc_addr_q <= addr_q;
            exc_sel_q  <= sel_q;
            state_q    <= FAULT;
          end
        end
        FWD: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        FAULT: begin
          if (exc_ack) begin
            exc_q       <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign exc       = exc_q;
  assign exc_addr  = exc_addr_q;
  assign exc_sel   = exc_sel_q;

endmodule

// File: tb/tb_mmu_bounds_guard.sv
// Bench for mmu_bounds_guard: directed and randomized requests, expectations
// pushed into a queue at issue time from a limit-table model, and a monitor
// that pops and compares whenever the guard raises mem_valid or exc.
`timescale 1ns/1ps
module tb_mmu_bounds_guard;
  localparam int ADDR_W = 26;
  localparam int SEL_W  = 4;
  localparam int NSEG   = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              we = 1'b0;
  logic [SEL_W-1:0]  sel = '0;
  logic [31:0]       lower = '0;
  logic [31:0]       upper = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_wr = 1'b0;
  logic              mem_valid;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic              exc;
  logic [ADDR_W-1:0] exc_addr;
  logic [SEL_W-1:0]  exc_sel;
  logic              exc_ack = 1'b0;

  mmu_bounds_guard #(.ADDR_W(ADDR_W), .SEL_W(SEL_W), .NSEG(NSEG)) dut (
    .clk(clk), .rst(rst), .we(we), .sel(sel), .lower(lower), .upper(upper),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wr(req_wr), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .exc(exc), .exc_addr(exc_addr),
    .exc_sel(exc_sel), .exc_ack(exc_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit                is_mem;
    logic [ADDR_W-1:0] addr;
    bit                wr;
    logic [SEL_W-1:0]  sel;
    int                cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: limits per selector and the selector last written.
  logic [31:0] lo_m [NSEG];
  logic [31:0] hi_m [NSEG];
  int          act_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NSEG; i++) begin
      lo_m[i] = 32'h0;
      hi_m[i] = 32'h0;
    end
    act_m = 0;
  endfunction

  function automatic void model_write(input int s, input logic [31:0] lo, input logic [31:0] hi);
    if (s < NSEG) begin
      lo_m[s] = lo;
      hi_m[s] = hi;
    end
    act_m = s;
  endfunction

  function automatic bit model_pass(input int s, input logic [ADDR_W-1:0] a);
    longint unsigned av;
    av = longint'(a);
    if (s >= NSEG) return 1'b0;
    return (av >= longint'(lo_m[s])) && (av <= longint'(hi_m[s]));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_table(input int s, input logic [31:0] lo, input logic [31:0] hi);
    we = 1'b1;
    sel = SEL_W'(s);
    lower = lo;
    upper = hi;
    model_write(s, lo, hi);
    tick();
    we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_mem_valid", 64'(mem_valid), 64'(0));
    chk("rst_exc", 64'(exc), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wr", 64'(mem_wr), 64'(0));
    chk("rst_exc_addr", 64'(exc_addr), 64'(0));
    chk("rst_exc_sel", 64'(exc_sel), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
  endtask

  // Issue one request; optionally write the table in the acceptance cycle
  // (sim_we), stall the response dly cycles with a table write in the first
  // stall cycle (mid_we), or abort it with reset (abort).
  task automatic do_req(input logic [ADDR_W-1:0] a, input bit w,
                        input bit sim_we, input int ws, input logic [31:0] wlo,
                        input logic [31:0] whi, input int dly, input bit mid_we,
                        input bit abort);
    exp_t e;
    int   guard;
    int   s;
    guard = 0;
    while (!req_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 64'(0), 64'(1));
      return;
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_wr    = w;
    s = act_m;
    if (sim_we) begin
      we = 1'b1;
      sel = SEL_W'(ws);
      lower = wlo;
      upper = whi;
      model_write(ws, wlo, whi);
    end
    e.is_mem = model_pass(s, a);
    e.addr   = a;
    e.wr     = w;
    e.sel    = SEL_W'(s);
    e.cyc    = cyc + 2;
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
    we = 1'b0;
    chk("req_ready_in_check", 64'(req_ready), 64'(0));
    tick();
    if (!(mem_valid || exc)) begin
      chk("response_timeout", 64'(0), 64'(1));
      return;
    end
    if (abort) begin
      tick();
      do_reset();
      return;
    end
    for (int i = 0; i < dly; i++) begin
      if (mid_we && i == 0) begin
        int rs;
        logic [31:0] rl;
        rs = $urandom_range(0, 15);
        rl = 32'($urandom_range(0, 32'h3FF));
        we = 1'b1;
        sel = SEL_W'(rs);
        lower = rl;
        upper = rl + 32'($urandom_range(0, 32'h300));
        model_write(rs, lower, upper);
      end
      tick();
      we = 1'b0;
    end
    if (mem_valid) mem_ready = 1'b1;
    else exc_ack = 1'b1;
    tick();
    mem_ready = 1'b0;
    exc_ack = 1'b0;
  endtask

  // Monitor: pops one expectation per mem_valid or exc rise.
  initial begin
    exp_t cur;
    bit   pmv;
    bit   pexc;
    pmv = 1'b0;
    pexc = 1'b0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_valid && exc) chk("mem_valid_with_exc", 64'(1), 64'(0));
        if (mem_valid && !pmv) begin
          if (exp_q.size() == 0) chk("unexpected_mem_valid", 64'(1), 64'(0));
          else begin
            cur = exp_q.pop_front();
            chk("kind_is_mem", 64'(1), 64'(cur.is_mem));
            chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
            chk("mem_wr", 64'(mem_wr), 64'(cur.wr));
            chk("mem_latency", 64'(cyc), 64'(cur.cyc));
          end
        end else if (mem_valid) begin
          chk("mem_addr_hold", 64'(mem_addr), 64'(cur.addr));
          chk("mem_wr_hold", 64'(mem_wr), 64'(cur.wr));
          chk("req_ready_in_fwd", 64'(req_ready), 64'(0));
        end
        if (exc && !pexc) begin
          if (exp_q.size() == 0) chk("unexpected_exc", 64'(1), 64'(0));
          else begin
            cur = exp_q.pop_front();
            chk("kind_is_fault", 64'(0), 64'(cur.is_mem));
            chk("exc_addr", 64'(exc_addr), 64'(cur.addr));
            chk("exc_sel", 64'(exc_sel), 64'(cur.sel));
            chk("exc_latency", 64'(cyc), 64'(cur.cyc));
          end
        end else if (exc) begin
          chk("exc_addr_hold", 64'(exc_addr), 64'(cur.addr));
          chk("req_ready_in_fault", 64'(req_ready), 64'(0));
        end
      end
      pmv = mem_valid;
      pexc = exc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic int rand_sel();
    if ($urandom_range(0, 7) == 0) return $urandom_range(NSEG, 15);
    return $urandom_range(0, NSEG - 1);
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return ADDR_W'($urandom);
    if (k <= 2 && act_m < NSEG) begin
      logic [31:0] b;
      b = ($urandom_range(0, 1) == 0) ? lo_m[act_m] : hi_m[act_m];
      b = b + 32'($urandom_range(0, 2)) - 32'd1;
      return ADDR_W'(b);
    end
    return ADDR_W'($urandom_range(0, 32'h7FF));
  endfunction

  initial begin
    model_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("init_mem_valid", 64'(mem_valid), 64'(0));
    chk("init_exc", 64'(exc), 64'(0));
    chk("init_mem_addr", 64'(mem_addr), 64'(0));
    chk("init_exc_addr", 64'(exc_addr), 64'(0));
    chk("init_exc_sel", 64'(exc_sel), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("init_req_ready", 64'(req_ready), 64'(1));

    // Unprogrammed table: only address 0 under selector 0.
    do_req(26'h0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    do_req(26'h1, 1'b1, 0, 0, 0, 0, 0, 0, 0);

    wr_table(2, 32'h100, 32'h1FF);
    do_req(26'h150, 1'b0, 0, 0, 0, 0, 1, 0, 0);
    do_req(26'h200, 1'b1, 0, 0, 0, 0, 2, 0, 0);
    do_req(26'h100, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    do_req(26'h1FF, 1'b1, 0, 0, 0, 0, 0, 0, 0);
    do_req(26'h0FF, 1'b0, 0, 0, 0, 0, 0, 0, 0);

    // Inverted window.
    wr_table(3, 32'h300, 32'h100);
    do_req(26'h200, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    do_req(26'h300, 1'b1, 0, 0, 0, 0, 0, 0, 0);
    do_req(26'h100, 1'b0, 0, 0, 0, 0, 0, 0, 0);

    // Invalid selector faults regardless of address.
    wr_table(12, 32'h0, 32'hFFFF_FFFF);
    do_req(26'h150, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    wr_table(2, 32'h100, 32'h1FF);
    do_req(26'h150, 1'b0, 0, 0, 0, 0, 0, 0, 0);

    // Long memory stall with a table write during FWD.
    do_req(26'h180, 1'b1, 0, 0, 0, 0, 5, 1, 0);

    // Same-cycle write and acceptance.
    wr_table(2, 32'h100, 32'h1FF);
    do_req(26'h150, 1'b0, 1, 2, 32'h0, 32'h10, 0, 0, 0);
    wr_table(2, 32'h100, 32'h1FF);
    do_req(26'h150, 1'b1, 1, 5, 32'h0, 32'hFFFF, 0, 0, 0);
    do_req(26'h8000, 1'b0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while in FAULT, then while in FWD.
    do_req(26'h20000, 1'b0, 0, 0, 0, 0, 0, 0, 1);
    do_req(26'h0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    do_req(26'h1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    wr_table(2, 32'h100, 32'h1FF);
    do_req(26'h150, 1'b1, 0, 0, 0, 0, 0, 0, 1);
    do_req(26'h0, 1'b1, 0, 0, 0, 0, 0, 0, 0);
    do_req(26'h1, 1'b1, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int          s;
        logic [31:0] lo;
        logic [31:0] hi;
        s  = rand_sel();
        lo = 32'($urandom_range(0, 32'h3FF));
        hi = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 32'h3FF))
                                         : lo + 32'($urandom_range(0, 32'h200));
        wr_table(s, lo, hi);
      end
      begin
        int          ws;
        logic [31:0] wl;
        ws = rand_sel();
        wl = 32'($urandom_range(0, 32'h3FF));
        do_req(rand_addr(), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
               ws, wl, wl + 32'($urandom_range(0, 32'h200)),
               $urandom_range(0, 3), $urandom_range(0, 3) == 0, 0);
      end
    end

    tick();
    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    chk("final_req_ready", 64'(req_ready), 64'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
